// File: rtl/draw_pkg.sv
// Shared definitions for the triangle draw arbiter.
// Holds the per-requester coordinate slice layout: each requester drives
// NCOORD coordinates of CORDW bits, with x0 in the lowest slice and y2 in the highest.
package draw_pkg;

  localparam int NCOORD = 6;

  localparam int X0_IDX = 0;
  localparam int Y0_IDX = 1;
  localparam int X1_IDX = 2;
  localparam int Y1_IDX = 3;
  localparam int X2_IDX = 4;
  localparam int Y2_IDX = 5;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: the lowest requester index at or after ptr wins, wrapping.
// Latency: purely combinational.
// Backpressure: none. The caller decides when to take the grant.
// Ports:
//   req         in  REQN   request vector
//   ptr         in  PTRW   index where the search starts
//   grant_valid out  1     at least one request is set
//   grant_idx   out  PTRW  winning index (0 when grant_valid is low)
module rr_arbiter #(
  parameter int REQN = 4,
  parameter int PTRW = $clog2(REQN)
) (
  input  logic [REQN-1:0] req,
  input  logic [PTRW-1:0] ptr,
  output logic            grant_valid,
  output logic [PTRW-1:0] grant_idx
);

  // Rotate the doubled vector so that bit 0 lines up with ptr. The lowest
  // set bit of the low half is then the first requester at or after ptr.
  logic [2*REQN-1:0] rot;

  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    rot         = {req, req} >> ptr;
    // Walk downward so that the lowest offset is the last one to assign.
    for (int i = REQN - 1; i >= 0; i--) begin
      if (rot[i]) begin
        grant_valid = 1'b1;
        grant_idx   = PTRW'((int'(ptr) + i) % REQN);
      end
    end
  end

endmodule

// File: rtl/draw_arbiter.sv
// Shares one triangle-fill engine among REQN requesters with round-robin grants.
// Latency: ack 1 cycle after the request is sampled, eng_start 1 cycle after that, req_done 1 cycle after eng_done.
// Backpressure: one triangle in flight. Other requests wait in IDLE until DONE. enable low holds off new grants only.
// Ports:
//   clk, rst           clock and asynchronous active-high reset
//   enable             allow new grants
//   req / req_coords / req_cidx   per-requester request, {x0..y2} slice and colour
//   ack / req_done     one-hot, single-cycle pulses to the owning requester
//   eng_start, eng_x0..eng_y2, eng_cidx, eng_done   engine handshake and operands
//   owner, busy        current grant holder and not-idle flag
module draw_arbiter
  import draw_pkg::*;
#(
  parameter int CORDW = 16,
  parameter int CIDXW = 4,
  parameter int REQN  = 4,
  parameter int SCALE = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable,
  input  logic [REQN-1:0]               req,
  input  logic [REQN*NCOORD*CORDW-1:0]  req_coords,
  input  logic [REQN*CIDXW-1:0]         req_cidx,
  output logic [REQN-1:0]               ack,
  output logic [REQN-1:0]               req_done,
  output logic                          eng_start,
  output logic signed [CORDW-1:0]       eng_x0,
  output logic signed [CORDW-1:0]       eng_y0,
  output logic signed [CORDW-1:0]       eng_x1,
  output logic signed [CORDW-1:0]       eng_y1,
  output logic signed [CORDW-1:0]       eng_x2,
  output logic signed [CORDW-1:0]       eng_y2,
  output logic [CIDXW-1:0]              eng_cidx,
  input  logic                          eng_done,
  output logic [$clog2(REQN)-1:0]       owner,
  output logic                          busy
);

  localparam int PTRW  = $clog2(REQN);
  localparam int SLICE = NCOORD * CORDW;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LATCH,
    S_START,
    S_DRAW,
    S_DONE
  } state_t;

  state_t              state_q;
  logic [PTRW-1:0]     owner_q;
  logic [PTRW-1:0]     rr_ptr_q;
  logic [REQN-1:0]     ack_q;
  logic [REQN-1:0]     req_done_q;
  logic                eng_start_q;
  logic                busy_q;
  logic [SLICE-1:0]    coords_q;
  logic [CIDXW-1:0]    cidx_q;

  logic                grant_valid;
  logic [PTRW-1:0]     grant_idx;
  logic [SLICE-1:0]    win_coords;
  logic [SLICE-1:0]    coords_d;
  logic [CIDXW-1:0]    cidx_d;
  logic [PTRW-1:0]     rr_ptr_d;
  logic [REQN-1:0]     ack_d;
  logic [REQN-1:0]     req_done_d;

  rr_arbiter #(
    .REQN (REQN),
    .PTRW (PTRW)
  ) u_rr (
    .req         (req),
    .ptr         (rr_ptr_q),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  // Winner's operands, scaled. The product keeps only CORDW bits, so large
  // coordinates wrap rather than saturate.
  always_comb begin
    win_coords = req_coords[grant_idx*SLICE +: SLICE];
    cidx_d     = req_cidx[grant_idx*CIDXW +: CIDXW];
    coords_d   = '0;
    for (int k = 0; k < NCOORD; k++) begin
      coords_d[k*CORDW +: CORDW] = win_coords[k*CORDW +: CORDW] * CORDW'(SCALE);
    end
  end

  assign ack_d      = REQN'(1) << grant_idx;
  assign req_done_d = REQN'(1) << owner_q;
  // The requester just served drops to lowest priority for the next pick.
  assign rr_ptr_d   = (owner_q == PTRW'(REQN - 1)) ? '0 : owner_q + PTRW'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      owner_q     <= '0;
      rr_ptr_q    <= '0;
      ack_q       <= '0;
      req_done_q  <= '0;
      eng_start_q <= 1'b0;
      busy_q      <= 1'b0;
      coords_q    <= '0;
      cidx_q      <= '0;
    end else begin
      // Strobes are set on entry to the state that owns them, so each lasts one cycle.
      ack_q       <= '0;
      req_done_q  <= '0;
      eng_start_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (enable && grant_valid) begin
            owner_q  <= grant_idx;
            coords_q <= coords_d;
            cidx_q   <= cidx_d;
            ack_q    <= ack_d;
            busy_q   <= 1'b1;
            state_q  <= S_LATCH;
          end
        end
        S_LATCH: begin
          eng_start_q <= 1'b1;
          state_q     <= S_START;
        end
        S_START: begin
          state_q <= S_DRAW;
        end
        S_DRAW: begin
          if (eng_done) begin
            req_done_q <= req_done_d;
            state_q    <= S_DONE;
          end
        end
        S_DONE: begin
          rr_ptr_q <= rr_ptr_d;
          busy_q   <= 1'b0;
          state_q  <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign ack       = ack_q;
  assign req_done  = req_done_q;
  assign eng_start = eng_start_q;
  assign owner     = owner_q;
  assign busy      = busy_q;
  assign eng_cidx  = cidx_q;
  assign eng_x0    = coords_q[X0_IDX*CORDW +: CORDW];
  assign eng_y0    = coords_q[Y0_IDX*CORDW +: CORDW];
  assign eng_x1    = coords_q[X1_IDX*CORDW +: CORDW];
  assign eng_y1    = coords_q[Y1_IDX*CORDW +: CORDW];
  assign eng_x2    = coords_q[X2_IDX*CORDW +: CORDW];
  assign eng_y2    = coords_q[Y2_IDX*CORDW +: CORDW];

endmodule

// File: tb/tb_draw_arbiter.sv
// Bench for draw_arbiter (REQN=4, CORDW=16, SCALE=2).
// Expected grants are queued as requests are raised and popped when ack appears.
// An engine model answers each eng_start with eng_done after a fixed delay.
module tb_draw_arbiter;

  localparam int CORDW = 16;
  localparam int CIDXW = 4;
  localparam int REQN  = 4;
  localparam int SCALE = 2;
  localparam int ENG_DELAY = 20;

  typedef struct packed {
    logic [1:0]  idx;
    logic [95:0] c;
    logic [3:0]  cidx;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         enable;
  logic [3:0]   req;
  logic [383:0] req_coords;
  logic [15:0]  req_cidx;
  logic [3:0]   ack;
  logic [3:0]   req_done;
  logic         eng_start;
  logic [15:0]  eng_x0, eng_y0, eng_x1, eng_y1, eng_x2, eng_y2;
  logic [3:0]   eng_cidx;
  logic         eng_done;
  logic         eng_done_m;
  logic         spur_done;
  logic [1:0]   owner;
  logic         busy;

  int checks   = 0;
  int failures = 0;

  exp_t exp_q[$];
  int   done_q[$];
  logic drawing;
  logic done_pending;
  logic start_next;

  assign eng_done = eng_done_m | spur_done;

  always #5 clk = ~clk;

  draw_arbiter #(
    .CORDW (CORDW),
    .CIDXW (CIDXW),
    .REQN  (REQN),
    .SCALE (SCALE)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .req        (req),
    .req_coords (req_coords),
    .req_cidx   (req_cidx),
    .ack        (ack),
    .req_done   (req_done),
    .eng_start  (eng_start),
    .eng_x0     (eng_x0),
    .eng_y0     (eng_y0),
    .eng_x1     (eng_x1),
    .eng_y1     (eng_y1),
    .eng_x2     (eng_x2),
    .eng_y2     (eng_y2),
    .eng_cidx   (eng_cidx),
    .eng_done   (eng_done),
    .owner      (owner),
    .busy       (busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic set_tri(input int idx, input int x0, input int y0, input int x1,
                         input int y1, input int x2, input int y2, input int cidx);
    int v[6];
    v = '{x0, y0, x1, y1, x2, y2};
    for (int k = 0; k < 6; k++) req_coords[(idx*6+k)*16 +: 16] = 16'(v[k]);
    req_cidx[idx*4 +: 4] = 4'(cidx);
  endtask

  // Expected operands: the requester's coordinates times SCALE, kept to 16 bits.
  task automatic push_exp(input int idx);
    exp_t        e;
    logic [15:0] v;
    logic [15:0] s;
    e.idx = 2'(idx);
    e.c   = '0;
    for (int k = 0; k < 6; k++) begin
      v = req_coords[(idx*6+k)*16 +: 16];
      s = v * 16'(SCALE);
      e.c[k*16 +: 16] = s;
    end
    e.cidx = req_cidx[idx*4 +: 4];
    exp_q.push_back(e);
  endtask

  task automatic wait_ack(output logic [3:0] a);
    a = '0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (ack != 0) begin
        a = ack;
        break;
      end
    end
    if (a == 0) chk("ack_timeout", {28'b0, a}, 32'd1);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (!busy) break;
    end
    chk("idle_timeout", {31'b0, busy}, 32'd0);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1 rst = 1'b0;
  endtask

  // Engine model: eng_done one cycle wide, ENG_DELAY cycles after eng_start.
  initial begin
    int cnt;
    cnt = 0;
    eng_done_m = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        cnt = 0;
        eng_done_m = 1'b0;
      end else begin
        eng_done_m = 1'b0;
        if (cnt > 0) begin
          cnt--;
          if (cnt == 0) eng_done_m = 1'b1;
        end
        if (eng_start) cnt = ENG_DELAY;
      end
    end
  end

  // Monitor: scores ack/operands against the queue, eng_start one cycle after
  // ack, req_done one cycle after an in-draw eng_done, and nothing else.
  initial begin
    exp_t       e;
    logic [3:0] exp_rd;
    logic       exp_st;
    drawing = 1'b0;
    done_pending = 1'b0;
    start_next = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_q.delete();
        done_q.delete();
        drawing = 1'b0;
        done_pending = 1'b0;
        start_next = 1'b0;
      end else begin
        exp_rd = '0;
        if (done_pending) begin
          done_pending = 1'b0;
          if (done_q.size() > 0) exp_rd = 4'b0001 << done_q.pop_front();
        end
        chk("req_done", {28'b0, req_done}, {28'b0, exp_rd});
        if (eng_done && drawing) begin
          done_pending = 1'b1;
          drawing = 1'b0;
        end
        exp_st = start_next;
        start_next = 1'b0;
        chk("eng_start", {31'b0, eng_start}, {31'b0, exp_st});
        if (eng_start) drawing = 1'b1;
        if (ack != 0) begin
          if (exp_q.size() == 0) begin
            chk("ack_unexpected", {28'b0, ack}, 32'd0);
          end else begin
            e = exp_q.pop_front();
            chk("ack",   {28'b0, ack},   {28'b0, 4'b0001 << e.idx});
            chk("owner", {30'b0, owner}, {30'b0, e.idx});
            chk("x0",    {16'b0, eng_x0}, {16'b0, e.c[15:0]});
            chk("y0",    {16'b0, eng_y0}, {16'b0, e.c[31:16]});
            chk("x1",    {16'b0, eng_x1}, {16'b0, e.c[47:32]});
            chk("y1",    {16'b0, eng_y1}, {16'b0, e.c[63:48]});
            chk("x2",    {16'b0, eng_x2}, {16'b0, e.c[79:64]});
            chk("y2",    {16'b0, eng_y2}, {16'b0, e.c[95:80]});
            chk("cidx",  {28'b0, eng_cidx}, {28'b0, e.cidx});
            done_q.push_back(int'(e.idx));
          end
          start_next = 1'b1;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] a;
    int         busy_seen;
    rst        = 1'b1;
    enable     = 1'b1;
    req        = '0;
    req_coords = '0;
    req_cidx   = '0;
    spur_done  = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_ack",   {28'b0, ack},      32'd0);
    chk("rst_done",  {28'b0, req_done}, 32'd0);
    chk("rst_start", {31'b0, eng_start}, 32'd0);
    chk("rst_busy",  {31'b0, busy},     32'd0);
    chk("rst_owner", {30'b0, owner},    32'd0);
    chk("rst_x0",    {16'b0, eng_x0},   32'd0);
    chk("rst_cidx",  {28'b0, eng_cidx}, 32'd0);
    @(negedge clk);
    #1 rst = 1'b0;

    // Single request, requester 0
    set_tri(0, 160, 90, 240, 90, 240, 170, 5);
    push_exp(0);
    req = 4'b0001;
    wait_ack(a);
    req = 4'b0000;
    wait_idle();
    chk("single_x1_hold", {16'b0, eng_x1}, 32'd480);

    // Simultaneous 1010 from rr_ptr=0: owner 1 then 3
    pulse_reset();
    set_tri(1, 11, 12, 13, 14, 15, 16, 1);
    set_tri(3, 31, 32, 33, 34, 35, 36, 3);
    push_exp(1);
    push_exp(3);
    req = 4'b1010;
    wait_ack(a);
    req = req & ~a;
    wait_ack(a);
    req = req & ~a;
    wait_idle();

    // Fairness: all four held for eight triangles
    for (int i = 0; i < 4; i++) set_tri(i, 10+i, 20+i, 30+i, 40+i, 50+i, 60+i, i+8);
    for (int n = 0; n < 8; n++) push_exp(n % 4);
    req = 4'b1111;
    for (int n = 0; n < 8; n++) wait_ack(a);
    req = 4'b0000;
    wait_idle();

    // Enable gating
    @(negedge clk);
    enable = 1'b0;
    set_tri(2, 1, 2, 3, 4, 5, 6, 7);
    req = 4'b0100;
    busy_seen = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (busy || ack != 0) busy_seen++;
    end
    chk("gate_quiet", 32'(busy_seen), 32'd0);
    push_exp(2);
    enable = 1'b1;
    @(negedge clk);
    chk("gate_ack", {28'b0, ack}, 32'b0100);
    req = 4'b0000;
    wait_idle();

    // Spurious eng_done while idle
    @(negedge clk);
    spur_done = 1'b1;
    @(negedge clk);
    spur_done = 1'b0;
    repeat (3) @(negedge clk);
    chk("spur_busy", {31'b0, busy}, 32'd0);

    // Scaling and truncation; rr_ptr is 3 so requester 3 goes before 1
    set_tri(3, 20000, -3, 100, 32767, -16384, 7, 15);
    set_tri(1, 200, 50, 160, 90, 240, 90, 9);
    push_exp(3);
    push_exp(1);
    req = 4'b1010;
    wait_ack(a);
    chk("trunc_x0", {16'b0, eng_x0}, 32'h9C40);
    chk("trunc_y1", {16'b0, eng_y1}, 32'hFFFE);
    req = req & ~a;
    wait_ack(a);
    chk("scale_x0", {16'b0, eng_x0}, 32'd400);
    chk("scale_y0", {16'b0, eng_y0}, 32'd100);
    chk("scale_x2", {16'b0, eng_x2}, 32'd480);
    req = req & ~a;
    wait_idle();

    // Reset mid-draw on requester 2, then requester 0 granted normally
    set_tri(2, 5, 6, 7, 8, 9, 10, 4);
    push_exp(2);
    req = 4'b0100;
    wait_ack(a);
    req = 4'b0000;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (eng_start) break;
    end
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_ack",   {28'b0, ack},       32'd0);
    chk("mid_rst_done",  {28'b0, req_done},  32'd0);
    chk("mid_rst_start", {31'b0, eng_start}, 32'd0);
    chk("mid_rst_busy",  {31'b0, busy},      32'd0);
    chk("mid_rst_owner", {30'b0, owner},     32'd0);
    chk("mid_rst_x0",    {16'b0, eng_x0},    32'd0);
    chk("mid_rst_cidx",  {28'b0, eng_cidx},  32'd0);
    set_tri(0, 160, 90, 240, 90, 240, 170, 6);
    req = 4'b0001;
    @(negedge clk);
    @(negedge clk);
    #1 rst = 1'b0;
    push_exp(0);
    wait_ack(a);
    req = 4'b0000;
    wait_idle();
    repeat (3) @(negedge clk);
    chk("end_queue", 32'(exp_q.size() + done_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
